// File: rtl/cmp_phase_ctrl.sv
// Clocked-comparator phase sequencer: non-overlapping P1/P2 phases with
// dead time, sample strobe, N-decision burst and majority-vote result.
// Ports:
//   clk, rst (async, active-high)
//   en_i, start_i, t_phase_i, t_dead_i, n_dec_i, cmp_out_i
//   cmp_p1_o, cmp_p2_o, sample_o, busy_o, done_o, result_o, ones_o
module cmp_phase_ctrl #(
  parameter int CNT_W  = 4,
  parameter int NDEC_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  t_phase_i,
  input  logic [CNT_W-1:0]  t_dead_i,
  input  logic [NDEC_W-1:0] n_dec_i,
  input  logic              cmp_out_i,
  output logic              cmp_p1_o,
  output logic              cmp_p2_o,
  output logic              sample_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              result_o,
  output logic [NDEC_W:0]   ones_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_DEAD1, S_P1, S_DEAD2, S_P2, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE = 1;
  localparam logic [NDEC_W-1:0] N_ONE = 1;

  state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  tp_q, tp_d;
  logic [CNT_W-1:0]  td_q, td_d;
  logic [NDEC_W-1:0] nd_q, nd_d;
  logic [NDEC_W:0]   dec_q, dec_d;
  logic [NDEC_W:0]   acc_q, acc_d;
  logic              result_d;
  logic [NDEC_W:0]   ones_d;
  logic              p1_d, p2_d, sample_d, busy_d, done_d;
  logic [CNT_W-1:0]  len;
  logic              last;

  // Dead states count t_dead, phase states count the effective phase length.
  assign len  = (state_q == S_P1 || state_q == S_P2) ? tp_q : td_q;
  assign last = (cnt_q == len - C_ONE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tp_d     = tp_q;
    td_d     = td_q;
    nd_d     = nd_q;
    dec_d    = dec_q;
    acc_d    = acc_q;
    result_d = result_o;
    ones_d   = ones_o;
    unique case (state_q)
      S_IDLE: begin
        if (en_i && start_i) begin
          tp_d    = (t_phase_i == '0) ? C_ONE : t_phase_i;
          td_d    = t_dead_i;
          nd_d    = (n_dec_i == '0) ? N_ONE : n_dec_i;
          dec_d   = '0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (t_dead_i == '0) ? S_P1 : S_DEAD1;
        end
      end
      S_DEAD1: begin
        if (last) begin
          cnt_d   = '0;
          state_d = S_P1;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_P1: begin
        if (last) begin
          cnt_d   = '0;
          acc_d   = acc_q + (NDEC_W+1)'(cmp_out_i);
          dec_d   = dec_q + 1'b1;
          state_d = (td_q == '0) ? S_P2 : S_DEAD2;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_DEAD2: begin
        if (last) begin
          cnt_d   = '0;
          state_d = S_P2;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_P2: begin
        if (last) begin
          cnt_d = '0;
          if (dec_q == {1'b0, nd_q})
            state_d = S_DONE;
          else
            state_d = (td_q == '0) ? S_P1 : S_DEAD1;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Dropping enable aborts silently; no result update.
    if (state_q != S_IDLE && !en_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end

    if (state_d == S_DONE) begin
      ones_d   = acc_q;
      result_d = ({acc_q, 1'b0} > {2'b00, nd_q});
    end

    p1_d     = (state_d == S_P1);
    p2_d     = (state_d == S_IDLE) || (state_d == S_P2);
    sample_d = (state_d == S_P1) && (cnt_d == tp_d - C_ONE);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tp_q     <= '0;
      td_q     <= '0;
      nd_q     <= '0;
      dec_q    <= '0;
      acc_q    <= '0;
      cmp_p1_o <= 1'b0;
      cmp_p2_o <= 1'b1;
      sample_o <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= 1'b0;
      ones_o   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tp_q     <= tp_d;
      td_q     <= td_d;
      nd_q     <= nd_d;
      dec_q    <= dec_d;
      acc_q    <= acc_d;
      cmp_p1_o <= p1_d;
      cmp_p2_o <= p2_d;
      sample_o <= sample_d;
      busy_o   <= busy_d;
      done_o   <= done_d;
      result_o <= result_d;
      ones_o   <= ones_d;
    end
  end

endmodule

// File: doc/cmp_phase_ctrl.md
Name: cmp_phase_ctrl

Overview:
Sequencer for the clocked comparator front-end. It generates the precharge phase (cmp_p2) and the evaluate phase (cmp_p1) with programmable phase lengths and non-overlap dead time, plus the sample strobe. It captures the comparator decision at the end of each evaluate phase. On request it runs a burst of N decisions, majority-votes them, and reports the result with a one-cycle done pulse to the measurement logic.

Parameters:
CNT_W, 4, width of phase/dead-time counters and config inputs
NDEC_W, 3, width of decision-count config and ones counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, active-high
en  input  1  block enable; low aborts any burst
start  input  1  burst request, single-cycle or level; honoured only in IDLE
t_phase  input  CNT_W  cycles per P1 and per P2 phase
t_dead  input  CNT_W  non-overlap cycles between phases
n_dec  input  NDEC_W  decisions per burst
cmp_out  input  1  comparator output, synchronous to clk
cmp_p1  output  1  evaluate phase
cmp_p2  output  1  precharge/reset phase
sample  output  1  one-cycle strobe in last P1 cycle
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse, burst complete
result  output  1  majority decision, valid with done, held until next done
ones  output  NDEC_W+1  count of cmp_out=1 decisions in last burst, held

Behaviour:
- Reset values: cmp_p1=0, cmp_p2=1, sample=0, busy=0, done=0, result=0, ones=0, state=IDLE, counters=0.
- All outputs are registered and decoded from the next state, so they change on the clock edge that enters a state.
- Phase outputs by state:
  - IDLE: p1=0, p2=1 (comparator held in precharge).
  - DEAD1, DEAD2, DONE: p1=0, p2=0.
  - P1: p1=1, p2=0.
  - P2: p1=0, p2=1.
- cmp_p1 and cmp_p2 are never high in the same cycle.
- IDLE: if en=1 and start=1, latch t_phase, t_dead and n_dec into shadow regs, clear the decision and ones counters, and go to DEAD1 (or straight to P1 if t_dead=0). Config changes mid-burst have no effect.
- Effective phase length is max(t_phase,1). Effective decision count is max(n_dec,1). t_dead=0 skips DEAD1 and DEAD2 entirely (zero cycles).
- DEAD1 lasts t_dead cycles, then P1.
- P1 lasts the effective phase length. sample=1 only in the final P1 cycle. On the edge leaving P1, cmp_out is captured: ones increments if cmp_out=1, and the decision counter increments. Then DEAD2.
- DEAD2 lasts t_dead cycles, then P2.
- P2 lasts the effective phase length. At the end of P2:
  - if decisions == effective n_dec, go to DONE;
  - otherwise go to DEAD1 (P1 if t_dead=0).
- DONE lasts 1 cycle: done=1, result=(2*ones > eff n_dec) with ties giving 0, ones output updated, then IDLE. start is ignored during DONE.
- en=0 in any non-IDLE state: synchronous abort to IDLE on the next edge. No done pulse; result and ones keep their previous values.
- start while busy: ignored, not queued.
- rst asserted mid-burst: immediate return to reset values, independent of clk.
- Counter arithmetic: unsigned; ones saturation is impossible because its width is NDEC_W+1.

Test Plan:
- Reset: assert rst mid-P1 -> cmp_p1=0, cmp_p2=1, busy=0 immediately, without waiting for a clk edge.
- Single decision: t_dead=1, t_phase=2, n_dec=1, cmp_out=1, start at edge 0:
  - phase sequence DEAD1(1), P1(2), DEAD2(1), P2(2);
  - sample high in P1 cycle 2 only;
  - done in cycle 7 after start, result=1, ones=1.
- Majority: n_dec=3, cmp_out pattern 1,0,1 at the three sample strobes -> ones=2, result=1. Pattern 0,1,0 -> ones=1, result=0. n_dec=4 with 1,1,0,0 -> tie, result=0.
- Zero configs: t_dead=0, t_phase=0, n_dec=0 -> P1(1), P2(1), one decision, no dead cycles; done 3 cycles after start; p1 and p2 never overlap.
- Abort and ignore:
  - start during busy -> no effect on the sequence;
  - drop en in P2 -> IDLE next edge, no done, prior result and ones unchanged;
  - config changed mid-burst -> burst timing unaffected.
- Non-overlap check across a 7-decision burst with t_dead=3, t_phase=5: assertion that p1&p2 is never high; exactly 7 sample pulses; each P1 is 5 cycles and each dead gap is 3 cycles.
